int_exec_unit: RTL

- Integer ALU execution stage, directly downstream of the integer reservation station.
- Pops one ready instruction per cycle from the issue queue using the issueque_ready/issueblk_done handshake.
- Executes the instruction in a registered ALU stage, then buffers the result in a small FIFO.
- Presents results to the CDB arbiter through a req/grant handshake; the arbiter broadcasts on cdb_tag/cdb_data/cdb_valid.

---
 rtl/int_exec_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/int_exec_unit.sv
// Integer ALU execution stage: pops the issue queue, registers the ALU result, buffers it in a
// small result FIFO and offers it to the CDB. Define INT_EXEC_STATS_EN to add issue/broadcast counters.
module int_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int RES_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issueque_ready,
    input  logic [3:0]            issueque_opcode,
    input  logic [DATA_WIDTH-1:0] issueque_rs1_data,
    input  logic [DATA_WIDTH-1:0] issueque_rs2_data,
    input  logic [TAG_WIDTH-1:0]  issueque_rd_tag,
    output logic                  issueblk_done,
    input  logic                  flush,
    output logic                  exu_cdb_req,
    input  logic                  exu_cdb_grant,
    output logic [TAG_WIDTH-1:0]  exu_cdb_tag,
    output logic [DATA_WIDTH-1:0] exu_cdb_data
`ifdef INT_EXEC_STATS_EN
    ,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_broadcast
`endif
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(RES_DEPTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_PASS = 4'b1010
    } alu_op_e;

    logic                  r_ex_valid;
    logic [TAG_WIDTH-1:0]  r_ex_tag;
    logic [DATA_WIDTH-1:0] r_ex_data;
    logic [TAG_WIDTH-1:0]  r_fifo_tag  [RES_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [RES_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW:0]           r_count;

    logic                  w_req;
    logic                  w_pop;
    logic                  w_ex_adv;
    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_alu_res;

    always_comb begin
        w_shamt   = issueque_rs2_data[4:0];
        w_alu_res = '0;
        case (alu_op_e'(issueque_opcode))
            OP_ADD:  w_alu_res = issueque_rs1_data + issueque_rs2_data;
            OP_SUB:  w_alu_res = issueque_rs1_data - issueque_rs2_data;
            OP_AND:  w_alu_res = issueque_rs1_data & issueque_rs2_data;
            OP_OR:   w_alu_res = issueque_rs1_data | issueque_rs2_data;
            OP_XOR:  w_alu_res = issueque_rs1_data ^ issueque_rs2_data;
            OP_SLL:  w_alu_res = issueque_rs1_data << w_shamt;
            OP_SRL:  w_alu_res = issueque_rs1_data >> w_shamt;
            OP_SRA:  w_alu_res = $signed(issueque_rs1_data) >>> w_shamt;
            OP_SLT:  w_alu_res = DATA_WIDTH'($signed(issueque_rs1_data) < $signed(issueque_rs2_data));
            OP_SLTU: w_alu_res = DATA_WIDTH'(issueque_rs1_data < issueque_rs2_data);
            OP_PASS: w_alu_res = issueque_rs2_data;
            default: w_alu_res = '0;
        endcase
    end

    // A full FIFO still accepts the EX entry when the head pops on the same edge.
    assign w_req         = (r_count != '0);
    assign w_pop         = w_req & exu_cdb_grant & ~flush;
    assign w_ex_adv      = r_ex_valid & ((r_count < FULL_CNT) | w_pop) & ~flush;
    assign issueblk_done = reset & issueque_ready & ~flush & (~r_ex_valid | w_ex_adv);

    assign exu_cdb_req  = w_req;
    assign exu_cdb_tag  = w_req ? r_fifo_tag[r_rd_ptr]  : '0;
    assign exu_cdb_data = w_req ? r_fifo_data[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid <= 1'b0;
            r_ex_tag   <= '0;
            r_ex_data  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (issueblk_done) begin
                r_ex_valid <= 1'b1;
                r_ex_tag   <= issueque_rd_tag;
                r_ex_data  <= w_alu_res;
            end else if (w_ex_adv) begin
                r_ex_valid <= 1'b0;
            end
            if (w_ex_adv) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_ex_adv && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_ex_adv && w_pop) r_count <= r_count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_ex_adv) begin
            r_fifo_tag[r_wr_ptr]  <= r_ex_tag;
            r_fifo_data[r_wr_ptr] <= r_ex_data;
        end
    end

`ifdef INT_EXEC_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued    <= '0;
            stat_broadcast <= '0;
        end else begin
            if (issueblk_done) stat_issued    <= stat_issued + 32'd1;
            if (w_pop)         stat_broadcast <= stat_broadcast + 32'd1;
        end
    end
`endif

endmodule
